// File: rtl/debug_unit_top.sv
// Debug unit stand-alone top: a host-side UART TX feeds the debug unit's
// UART RX; the debug unit decodes commands, owns a small debug memory and
// a step counter, and answers through its own UART TX on o_tx.

// Serialises one byte as 8N1, starting on the first baud tick after start.
module du_uart_tx #(
    parameter int BYTE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            start,
    input  logic [BYTE-1:0] din,
    output logic            tx,
    output logic            done
);
    localparam int BW = $clog2(BYTE);
    typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [BYTE-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    // Next-state logic: each bit lasts 16 ticks, line level is registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    shift_d = din;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: if (tick) begin
                tx_d    = 1'b0;
                cnt_d   = 4'd0;
                state_d = TX_START;
            end
            TX_START: if (tick) begin
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            TX_DATA: if (tick) begin
                if (cnt_q == 4'd15) begin
                    cnt_d = 4'd0;
                    if (bit_q == BW'(BYTE-1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            TX_STOP: if (tick) begin
                if (cnt_q == 4'd15) begin
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset (line idles high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= 4'd0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign done = done_q;
endmodule

// Receives one 8N1 byte: start re-checked at tick 8, data sampled mid-bit.
module du_uart_rx #(
    parameter int BYTE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            rx,
    output logic [BYTE-1:0] dout,
    output logic            done
);
    localparam int BW = $clog2(BYTE);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [BYTE-1:0] shift_q, shift_d;
    logic            prev_q, prev_d;
    logic            done_q, done_d;

    // Next-state logic: falling edge arms reception, bad stop drops the byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        prev_d  = rx;
        done_d  = 1'b0;
        case (state_q)
            RX_IDLE: if (prev_q && !rx) begin
                cnt_d   = 4'd0;
                state_d = RX_START;
            end
            RX_START: if (tick) begin
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    bit_d   = '0;
                    state_d = rx ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RX_DATA: if (tick) begin
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    shift_d = {rx, shift_q[BYTE-1:1]};
                    if (bit_q == BW'(BYTE-1)) state_d = RX_STOP;
                    else bit_d = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RX_STOP: if (tick) begin
                if (cnt_q == 4'd15) begin
                    done_d  = rx;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= 4'd0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            done_q  <= done_d;
        end
    end

    assign dout = shift_q;
    assign done = done_q;
endmodule

module debug_unit_top #(
    parameter int BYTE     = 8,
    parameter int ADDR     = 7,
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [BYTE-1:0] command,
    input  logic            send,
    output logic            o_tx,
    output logic            o_busy,
    output logic [BYTE-1:0] o_step_count
);
    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << ADDR;
    localparam logic [BYTE-1:0] CMD_DUMP   = BYTE'(8'h04);
    localparam logic [BYTE-1:0] CMD_WRITE  = BYTE'(8'h05);
    localparam logic [BYTE-1:0] CMD_STEP   = BYTE'(8'h06);
    localparam logic [BYTE-1:0] CMD_STATUS = BYTE'(8'h07);
    localparam logic [BYTE-1:0] ACK        = BYTE'(8'hAA);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_DUMP, S_WR_ADDR, S_WR_DATA, S_REPLY, S_WAIT_TX} du_state_t;

    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic            tick;
    logic            line;
    logic            host_tx_done_unused;
    logic [BYTE-1:0] rx_data;
    logic            rx_done;
    logic            tx_done;

    du_state_t       state_q, state_d;
    logic [BYTE-1:0] cmd_q, cmd_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [ADDR-1:0] idx_q, idx_d;
    logic [ADDR-1:0] idx_inc;
    logic [BYTE-1:0] step_q, step_d;
    logic [BYTE-1:0] reply_q, reply_d;
    logic            tx_start_q, tx_start_d;
    logic [BYTE-1:0] tx_data_q, tx_data_d;
    logic            mem_we;
    logic [BYTE-1:0] mem_q [DEPTH];

    // Shared 16x oversampling tick for both UART ends.
    always_comb begin
        baud_cnt_d = (tick) ? '0 : baud_cnt_q + CW'(1);
    end
    assign tick = (baud_cnt_q == CW'(DIV - 1));

    // Baud counter register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) baud_cnt_q <= '0;
        else          baud_cnt_q <= baud_cnt_d;
    end

    du_uart_tx #(.BYTE(BYTE)) u_host_tx (
        .clk(i_clock), .rst_n(i_reset), .tick(tick), .start(send), .din(command),
        .tx(line), .done(host_tx_done_unused)
    );

    du_uart_rx #(.BYTE(BYTE)) u_du_rx (
        .clk(i_clock), .rst_n(i_reset), .tick(tick), .rx(line),
        .dout(rx_data), .done(rx_done)
    );

    du_uart_tx #(.BYTE(BYTE)) u_du_tx (
        .clk(i_clock), .rst_n(i_reset), .tick(tick), .start(tx_start_q), .din(tx_data_q),
        .tx(o_tx), .done(tx_done)
    );

    assign idx_inc = idx_q + 1'b1;
    assign mem_we  = (state_q == S_WR_DATA) && rx_done;

    // Command FSM: received bytes outside IDLE/WR_ADDR/WR_DATA are dropped.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        step_d     = step_q;
        reply_d    = reply_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: if (rx_done) begin
                cmd_d   = rx_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (cmd_q == CMD_DUMP) begin
                    idx_d      = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[0];
                    state_d    = S_DUMP;
                end else if (cmd_q == CMD_WRITE) begin
                    state_d = S_WR_ADDR;
                end else if (cmd_q == CMD_STEP) begin
                    step_d  = step_q + 1'b1;
                    reply_d = step_q + 1'b1;
                    state_d = S_REPLY;
                end else if (cmd_q == CMD_STATUS) begin
                    reply_d = step_q;
                    state_d = S_REPLY;
                end
            end
            S_DUMP: if (tx_done) begin
                if (idx_q == {ADDR{1'b1}}) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d      = idx_inc;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[idx_inc];
                end
            end
            S_WR_ADDR: if (rx_done) begin
                addr_d  = rx_data[ADDR-1:0];
                state_d = S_WR_DATA;
            end
            S_WR_DATA: if (rx_done) begin
                reply_d = ACK;
                state_d = S_REPLY;
            end
            S_REPLY: begin
                tx_start_d = 1'b1;
                tx_data_d  = reply_q;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command FSM registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            step_q     <= '0;
            reply_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            reply_q    <= reply_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Debug memory: each entry reloads its own address on reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge i_clock) begin
            if (!i_reset)                              mem_q[gi] <= BYTE'(gi);
            else if (mem_we && addr_q == ADDR'(gi))   mem_q[gi] <= rx_data;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_step_count = step_q;
endmodule

// File: tb/tb_debug_unit_top.sv
// Directed bench for debug_unit_top. Baud divider forced to 1 so one
// serial bit lasts 16 clocks and a frame 160 clocks.
module tb_debug_unit_top;
    localparam int BYTE = 8;
    localparam int ADDR = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [BYTE-1:0] command = '0;
    logic            send = 1'b0;
    logic            o_tx;
    logic            o_busy;
    logic [BYTE-1:0] o_step_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debug_unit_top #(.BYTE(BYTE), .ADDR(ADDR), .CLK_FREQ(1600), .BAUD(100)) dut (
        .i_clock(clk), .i_reset(rst_n), .command(command), .send(send),
        .o_tx(o_tx), .o_busy(o_busy), .o_step_count(o_step_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        command = b;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
        $display("host send 0x%02h", b);
    endtask

    task automatic wait_busy(input logic level, input int limit, output int cycles);
        cycles = 0;
        while (o_busy !== level && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Decode one frame from o_tx; got=0 on timeout or framing error.
    task automatic recv_byte(input int timeout, output logic [7:0] b, output bit got);
        int n = 0;
        b   = '0;
        got = 1'b0;
        while (o_tx !== 1'b0 && n < timeout) begin
            @(negedge clk);
            n++;
        end
        if (o_tx !== 1'b0) return;
        repeat (8) @(negedge clk);
        if (o_tx !== 1'b0) return;
        for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge clk);
            b[k] = o_tx;
        end
        repeat (16) @(negedge clk);
        got = (o_tx === 1'b1);
        $display("du reply 0x%02h frame_ok=%0d", b, got);
    endtask

    task automatic dump_check(input string name, input int n, input int sp_addr, input logic [7:0] sp_val);
        logic [7:0] b;
        logic [7:0] exp;
        bit got;
        for (int i = 0; i < n; i++) begin
            recv_byte(2000, b, got);
            exp = (i == sp_addr) ? sp_val : 8'(i);
            check($sformatf("%s frame %0d received", name, i), 32'(got), 32'd1);
            if (!got) break;
            check($sformatf("%s byte %0d", name, i), 32'(b), 32'(exp));
        end
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit got;
        int cyc;
        int cyc2;

        // Reset held low for 5 cycles.
        repeat (5) @(negedge clk);
        check("reset o_tx", 32'(o_tx), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset o_tx", 32'(o_tx), 32'd1);
        check("post-reset o_busy", 32'(o_busy), 32'd0);
        check("post-reset step", 32'(o_step_count), 32'd0);

        // Full dump of the identity memory.
        send_cmd(8'h04);
        wait_busy(1'b1, 400, cyc);
        check("dump1 busy rose", 32'(o_busy), 32'd1);
        check("dump1 busy after ~1 frame", 32'(cyc >= 140 && cyc <= 180), 32'd1);
        dump_check("dump1", 128, -1, 8'h00);
        wait_busy(1'b0, 100, cyc);
        check("dump1 busy fell", 32'(o_busy), 32'd0);

        // Step three times, then status.
        for (int k = 1; k <= 3; k++) begin
            send_cmd(8'h06);
            recv_byte(1000, b, got);
            check($sformatf("step%0d reply received", k), 32'(got), 32'd1);
            check($sformatf("step%0d reply", k), 32'(b), 32'(k));
            check($sformatf("step%0d count", k), 32'(o_step_count), 32'(k));
            wait_busy(1'b0, 100, cyc);
        end
        send_cmd(8'h07);
        recv_byte(1000, b, got);
        check("status reply received", 32'(got), 32'd1);
        check("status reply", 32'(b), 32'h03);
        check("status count", 32'(o_step_count), 32'h03);
        wait_busy(1'b0, 100, cyc);

        // Write mem[0x10] = 0x5A.
        send_cmd(8'h05);
        repeat (200) @(negedge clk);
        check("write busy in WR_ADDR", 32'(o_busy), 32'd1);
        send_cmd(8'h10);
        repeat (200) @(negedge clk);
        send_cmd(8'h5A);
        recv_byte(1000, b, got);
        check("write ack received", 32'(got), 32'd1);
        check("write ack", 32'(b), 32'hAA);
        wait_busy(1'b0, 100, cyc);
        check("write busy fell", 32'(o_busy), 32'd0);

        // Dump shows the written byte.
        send_cmd(8'h04);
        dump_check("dump2", 128, 16, 8'h5A);
        wait_busy(1'b0, 100, cyc);
        check("dump2 busy fell", 32'(o_busy), 32'd0);

        // Unknown command: short busy pulse, no reply.
        send_cmd(8'h09);
        wait_busy(1'b1, 400, cyc);
        check("unknown busy pulse", 32'(o_busy), 32'd1);
        wait_busy(1'b0, 10, cyc2);
        check("unknown busy <=2 cycles", 32'(cyc2 <= 2 && o_busy === 1'b0), 32'd1);
        recv_byte(400, b, got);
        check("unknown no reply", 32'(got), 32'd0);

        // Reset in the middle of a dump (inside frame for byte 0x14, bit 1 = 0).
        send_cmd(8'h04);
        dump_check("dump3", 20, 16, 8'h5A);
        cyc = 0;
        while (o_tx !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (40) @(negedge clk);
        check("dump3 mid-frame line low", 32'(o_tx), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-dump reset o_tx", 32'(o_tx), 32'd1);
        check("mid-dump reset o_busy", 32'(o_busy), 32'd0);
        check("mid-dump reset step", 32'(o_step_count), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("after reset line idle", 32'(o_tx), 32'd1);

        // Restarted dump from 0x00 with memory back to identity.
        send_cmd(8'h04);
        dump_check("dump4", 17, -1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_unit_top.md
Name: debug_unit_top

Overview:
Self-contained debug-unit test top. A host-side UART transmitter serialises a command byte presented on `command`/`send` onto an internal serial line. The debug unit receives it through its own UART receiver, decodes it, and answers through its own UART transmitter on `o_tx`. The debug unit owns a 2^ADDR x BYTE debug memory and an 8-bit step counter. The block sits between the host serial link and the processor debug logic, and is used stand-alone in simulation.

Parameters:
BYTE, 8, data/command width in bits (UART payload width).
ADDR, 7, debug memory address width (memory depth 2^ADDR = 128).
CLK_FREQ, 50000000, clock frequency in Hz.
BAUD, 9600, serial rate in bit/s; oversampling is fixed at 16x.

Ports:
i_clock  in  1  system clock; all logic on rising edge.
i_reset  in  1  synchronous, active-low reset.
command  in  BYTE  command byte to transmit from the host side.
send  in  1  single-cycle strobe: latch `command` and transmit it.
o_tx  out  1  debug-unit serial reply line, 8N1, idle high.
o_busy  out  1  high while the debug-unit FSM is not in IDLE.
o_step_count  out  BYTE  current step counter.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - o_tx=1, o_busy=0, o_step_count=0.
  - mem[i]=i[BYTE-1:0] for all i.
  - All FSMs go to IDLE.
  - The baud counter clears.
  - Reset mid-frame aborts any transfer immediately.
- Baud tick:
  - Single-cycle pulse every CLK_FREQ/(BAUD*16) cycles, integer-truncated (325 at defaults).
  - One bit lasts 16 ticks (5200 cycles). One frame = 1 start (0), 8 data LSB-first, 1 stop (1) = 52000 cycles.
- Host TX:
  - When idle, `send`=1 latches `command` on that edge, and the frame starts on the next tick.
  - `send` while the host TX is busy is ignored (no queue).
- DU RX:
  - A falling edge on the line starts reception. The start bit is re-checked at tick 8 of the start bit; if it reads high, the RX returns to idle.
  - Data bits are sampled mid-bit (tick 8).
  - A valid stop bit (1) produces a one-cycle rx_done with the byte. A stop bit of 0 discards the byte.
- DU FSM states: IDLE, DECODE, DUMP, WR_ADDR, WR_DATA, REPLY, WAIT_TX.
  - IDLE: on rx_done, go to DECODE.
  - 0x04 DUMP: transmit mem[0] .. mem[2^ADDR-1] in address order, back-to-back. Each byte starts when the DU TX reports done, with no idle gap beyond one cycle. Then return to IDLE.
  - 0x05 WRITE: the next received byte is the address (low ADDR bits used, upper bits ignored). The byte after that is the data. Write mem[addr]=data, transmit ack 0xAA, return to IDLE.
  - 0x06 STEP: o_step_count += 1 (wraps 0xFF->0x00). Transmit the new value.
  - 0x07 STATUS: transmit o_step_count unchanged.
  - Any other byte: ignored, no reply, back to IDLE.
- Bytes received while the FSM is in DUMP/REPLY/WAIT_TX are dropped.
- o_busy=1 in every state except IDLE.
- DU TX has the same framing as host TX. o_tx is held high between frames.

Test Plan:
- Reset for 5 cycles, release -> o_tx=1, o_busy=0, o_step_count=0x00.
- command=0x04, one-cycle send -> o_busy rises about 1 frame (about 52000 cycles) later. o_tx then carries 128 frames with data 0x00,0x01,...,0x7F, then o_busy=0.
- command=0x06 sent three times about 1.2 ms apart -> replies 0x01, 0x02, 0x03. Then 0x07 -> reply 0x03, o_step_count=3.
- Send 0x05, 0x10, 0x5A -> reply 0xAA. A following 0x04 dump shows byte 16 = 0x5A and all others equal to their address.
- Send 0x09 -> no frame on o_tx; o_busy returns to 0 within 2 cycles of rx_done.
- Assert reset midway through a dump -> o_tx=1 next cycle, counter 0, memory restored to the identity pattern; a new 0x04 dump starts again at 0x00.
